// File: rtl/lfsr_share_if.sv
// Request/response bundle between the two requesters, the response consumer
// and lfsr_share_ctrl.
interface lfsr_share_if #(
  parameter int STEP_W = 4
);
  logic              req0_valid;
  logic              req0_ready;
  logic              req0_load;
  logic [5:0]        req0_seed;
  logic [STEP_W-1:0] req0_steps;

  logic              req1_valid;
  logic              req1_ready;
  logic              req1_load;
  logic [5:0]        req1_seed;
  logic [STEP_W-1:0] req1_steps;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [5:0]        rsp_data;
  logic              rsp_id;

  modport master (
    output req0_valid, req0_load, req0_seed, req0_steps,
    output req1_valid, req1_load, req1_seed, req1_steps,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_data, rsp_id,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_load, req0_seed, req0_steps,
    input  req1_valid, req1_load, req1_seed, req1_steps,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_data, rsp_id,
    input  rsp_ready
  );
endinterface

// File: rtl/lfsr_share_ctrl.sv
// Round-robin sharing of one external 6-bit parallel-load LFSR between two
// requesters: optional seed, N steps, result returned on a valid/ready channel.
module lfsr_share_ctrl #(
  parameter int         STEP_W       = 4,
  parameter logic [5:0] DEFAULT_SEED = 6'h20
) (
  input  logic       clk,
  input  logic       rst_n,
  lfsr_share_if.slave bus,
  output logic       lfsr_sel,
  output logic [5:0] lfsr_pin,
  input  logic [5:0] lfsr_pout,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, RESP} state_t;

  typedef struct packed {
    logic       id;
    logic       load;
    logic [5:0] seed;
  } cap_t;

  state_t            state, state_nxt;
  cap_t              cap, cap_nxt;
  logic [STEP_W-1:0] cnt, cnt_nxt;
  logic              rr_ptr, rr_nxt;

  logic [1:0]              req_vld;
  logic [1:0]              gnt;
  logic [1:0]              req_load;
  logic [1:0][5:0]         req_seed;
  logic [1:0][STEP_W-1:0]  req_steps;

  assign req_vld   = {bus.req1_valid, bus.req0_valid};
  assign req_load  = {bus.req1_load,  bus.req0_load};
  assign req_seed  = {bus.req1_seed,  bus.req0_seed};
  assign req_steps = {bus.req1_steps, bus.req0_steps};

  // Grants only in IDLE; on contention rr_ptr picks the winner.
  always_comb begin
    gnt = 2'b00;
    if (rst_n && state == IDLE) begin
      if (req_vld[0] && (!req_vld[1] || !rr_ptr)) gnt[0] = 1'b1;
      else if (req_vld[1])                         gnt[1] = 1'b1;
    end
  end

  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cap    <= '0;
      cnt    <= '0;
      rr_ptr <= 1'b0;
    end else begin
      state  <= state_nxt;
      cap    <= cap_nxt;
      cnt    <= cnt_nxt;
      rr_ptr <= rr_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cap_nxt       = cap;
    cnt_nxt       = cnt;
    rr_nxt        = rr_ptr;
    lfsr_sel      = 1'b0;
    lfsr_pin      = lfsr_pout;
    bus.rsp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (gnt != 2'b00) begin
          cap_nxt.id   = gnt[1];
          cap_nxt.load = req_load[gnt[1]];
          cap_nxt.seed = req_seed[gnt[1]];
          cnt_nxt      = req_steps[gnt[1]];
          if (req_load[gnt[1]])              state_nxt = LOAD;
          else if (req_steps[gnt[1]] != '0) state_nxt = SHIFT;
          else                               state_nxt = RESP;
        end
      end
      LOAD: begin
        lfsr_pin  = (cap.seed == 6'h00) ? DEFAULT_SEED : cap.seed;
        state_nxt = (cnt != '0) ? SHIFT : RESP;
      end
      SHIFT: begin
        // A locked all-zero register is reseeded; that cycle still counts as a step.
        if (lfsr_pout == 6'h00) lfsr_pin = DEFAULT_SEED;
        else                    lfsr_sel = 1'b1;
        cnt_nxt = cnt - 1'b1;
        if (cnt <= 1) state_nxt = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_nxt = IDLE;
          rr_nxt    = ~cap.id;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!rst_n) begin
      lfsr_sel = 1'b0;
      lfsr_pin = 6'h00;
    end
  end

  assign bus.rsp_data = bus.rsp_valid ? lfsr_pout : 6'h00;
  assign bus.rsp_id   = cap.id;
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_lfsr_share_ctrl.sv
// Directed bench for lfsr_share_ctrl with a behavioural external LFSR.
module tb_lfsr_share_ctrl;
  localparam int STEP_W = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lfsr_sel;
  logic [5:0] lfsr_pin;
  logic [5:0] lfsr_pout;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int sel_cnt  = 0;
  int both_cnt = 0;

  lfsr_share_if #(.STEP_W(STEP_W)) bus ();

  lfsr_share_ctrl #(.STEP_W(STEP_W), .DEFAULT_SEED(6'h20)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .lfsr_sel(lfsr_sel), .lfsr_pin(lfsr_pin), .lfsr_pout(lfsr_pout), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] lfsr_step(input logic [5:0] s);
    return {s[4:0], 1'b0} ^ (s[5] ? 6'h0B : 6'h00) ^ (s[4] ? 6'h02 : 6'h00);
  endfunction

  // External LFSR: sel=0 parallel load, sel=1 shift, resets to 0.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)        lfsr_pout <= 6'h00;
    else if (lfsr_sel) lfsr_pout <= lfsr_step(lfsr_pout);
    else               lfsr_pout <= lfsr_pin;
  end

  always @(posedge clk) begin
    if (rst_n && lfsr_sel) sel_cnt <= sel_cnt + 1;
    if (bus.req0_ready && bus.req1_ready) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int id, input logic v, input logic ld, input logic [5:0] sd,
                         input logic [STEP_W-1:0] st);
    if (id == 0) begin
      bus.req0_valid = v; bus.req0_load = ld; bus.req0_seed = sd; bus.req0_steps = st;
    end else begin
      bus.req1_valid = v; bus.req1_load = ld; bus.req1_seed = sd; bus.req1_steps = st;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Issue one request, return cycles from the accepting edge to rsp_valid.
  task automatic issue(input int id, input logic ld, input logic [5:0] sd,
                       input logic [STEP_W-1:0] st, output int lat);
    int n = 0;
    set_req(id, 1'b1, ld, sd, st);
    #1;
    while (!(id == 0 ? bus.req0_ready : bus.req1_ready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) chk("grant_timeout", 0, 1);
    @(negedge clk);
    set_req(id, 1'b0, 1'b0, 6'h00, '0);
    lat = 1;
    while (!bus.rsp_valid && lat < 40) begin
      @(negedge clk); lat++;
    end
    if (lat >= 40) chk("rsp_timeout", 0, 1);
  endtask

  task automatic take_rsp();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int s0;
    int n;
    set_req(0, 1'b0, 1'b0, 6'h00, '0);
    set_req(1, 1'b0, 1'b0, 6'h00, '0);
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;

    // Reset state, with a valid held to confirm ready stays low
    bus.req0_valid = 1'b1;
    #12;
    chk("rst_ready0", bus.req0_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sel", lfsr_sel, 0);
    chk("rst_pin", lfsr_pin, 0);
    bus.req0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Seed + one step
    issue(0, 1'b1, 6'h20, 4'd1, lat);
    chk("t1_lat", lat, 3);
    chk("t1_data", bus.rsp_data, 6'h0B);
    chk("t1_id", bus.rsp_id, 0);
    take_rsp();
    repeat (3) @(negedge clk);
    chk("t1_hold", lfsr_pout, 6'h0B);
    chk("t1_idle_busy", busy, 0);

    // Three steps from requester 1, then a zero-step read from requester 0
    s0 = sel_cnt;
    issue(1, 1'b1, 6'h20, 4'd3, lat);
    chk("t2_lat", lat, 5);
    chk("t2_sel_cycles", sel_cnt - s0, 3);
    chk("t2_data", bus.rsp_data, 6'h2E);
    chk("t2_id", bus.rsp_id, 1);
    take_rsp();
    issue(0, 1'b0, 6'h00, 4'd0, lat);
    chk("t2_read_lat", lat, 1);
    chk("t2_read_data", bus.rsp_data, 6'h2E);
    take_rsp();
    // rsp_ready outside RESP is ignored
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("t2_idle_rsp_valid", bus.rsp_valid, 0);

    // Contention: grants must alternate starting at 0
    do_reset();
    s0 = both_cnt;
    set_req(0, 1'b1, 1'b1, 6'h20, 4'd2);
    set_req(1, 1'b1, 1'b1, 6'h20, 4'd2);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!bus.rsp_valid && n < 20) begin
        @(negedge clk); n++;
      end
      if (n >= 20) chk("t3_timeout", 0, 1);
      chk("t3_id", bus.rsp_id, k % 2);
      chk("t3_data", bus.rsp_data, 6'h16);
      take_rsp();
    end
    set_req(0, 1'b0, 1'b0, 6'h00, '0);
    set_req(1, 1'b0, 1'b0, 6'h00, '0);
    chk("t3_one_ready", both_cnt - s0, 0);
    repeat (8) @(negedge clk);

    // Zero-state recovery straight out of reset
    do_reset();
    s0 = sel_cnt;
    issue(0, 1'b0, 6'h00, 4'd2, lat);
    chk("t4_lat", lat, 3);
    chk("t4_data", bus.rsp_data, 6'h0B);
    chk("t4_sel_cycles", sel_cnt - s0, 1);
    take_rsp();

    // Zero seed substitutes DEFAULT_SEED; response held under backpressure
    issue(0, 1'b1, 6'h00, 4'd1, lat);
    chk("t5_lat", lat, 3);
    chk("t5_data", bus.rsp_data, 6'h0B);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t5_hold_valid", bus.rsp_valid, 1);
      chk("t5_hold_data", bus.rsp_data, 6'h0B);
      chk("t5_hold_id", bus.rsp_id, 0);
      chk("t5_hold_lfsr", lfsr_pout, 6'h0B);
    end
    take_rsp();

    // Reset asserted in the middle of a long SHIFT
    set_req(0, 1'b1, 1'b1, 6'h20, 4'd15);
    #1;
    chk("t6_grant", bus.req0_ready, 1);
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 6'h00, '0);
    repeat (2) @(negedge clk);
    chk("t6_in_shift", lfsr_sel, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", bus.rsp_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_sel", lfsr_sel, 0);
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 1'b1, 1'b0, 6'h00, '0);
    set_req(1, 1'b1, 1'b0, 6'h00, '0);
    #1;
    chk("t6_rr_ready0", bus.req0_ready, 1);
    chk("t6_rr_ready1", bus.req1_ready, 0);
    bus.req0_valid = 1'b0;
    #1;
    chk("t6_solo_ready1", bus.req1_ready, 1);
    set_req(1, 1'b0, 1'b0, 6'h00, '0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lfsr_share_ctrl.md
Name: lfsr_share_ctrl

Overview:
Controller that shares one external 6-bit parallel-load LFSR (sel=0 load, sel=1 shift; reset state 0) between two requesters. It round-robin arbitrates the requests and optionally seeds the LFSR. It then advances the LFSR a requested number of steps and returns the resulting word on a valid/ready response channel. It also owns hold-by-reload and recovery from the all-zero lock state.

Parameters:
STEP_W, 4, width of the step-count field (max steps 2^STEP_W-1)
DEFAULT_SEED, 6'h20, seed substituted for zero seeds and zero-state recovery; must be nonzero

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req0_valid  in  1  requester 0 request valid
req0_ready  out  1  requester 0 accept
req0_load  in  1  1 = load seed before stepping
req0_seed  in  6  seed value
req0_steps  in  STEP_W  number of LFSR steps
req1_valid, req1_ready, req1_load, req1_seed, req1_steps  same as requester 0
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_data  out  6  LFSR value returned
rsp_id  out  1  requester served (0/1)
lfsr_sel  out  1  to LFSR sel
lfsr_pin  out  6  to LFSR parallel_in
lfsr_pout  in  6  from LFSR parallel_out
busy  out  1  high in any state except IDLE

Behaviour:
- Reset, clk and rst_n: reset is asynchronous, active-low (rst_n); clock is clk. Reset drives state=IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0, req*_ready=0, busy=0, lfsr_sel=0, lfsr_pin=0, internal counters/captures=0.
- Reset mid-operation: abort immediately, drop any pending response, return to IDLE.
- FSM states: IDLE, LOAD, SHIFT, RESP.
- Hold rule: in IDLE and RESP, lfsr_sel=0 and lfsr_pin=lfsr_pout, so the LFSR holds its value.
- IDLE / arbitration:
  - Only one reqN_ready may be high, and only in IDLE; it is combinational from the valids and rr_ptr.
  - One valid: grant it.
  - Both valid: grant rr_ptr (0 = req0).
  - Handshake on valid&&ready: capture id, load, seed, steps.
  - Next state: LOAD if load=1; else SHIFT if steps>0; else RESP.
- LOAD (1 cycle): lfsr_sel=0, lfsr_pin = (seed==0 ? DEFAULT_SEED : seed). Next: SHIFT if steps>0, else RESP.
- SHIFT:
  - Lasts exactly `steps` cycles; the step counter decrements every cycle.
  - Normally lfsr_sel=1.
  - If lfsr_pout==0 at a SHIFT cycle: lfsr_sel=0, lfsr_pin=DEFAULT_SEED. This reseed counts as one step.
  - Exit to RESP on the edge where the counter goes 1→0.
- RESP:
  - rsp_valid=1, rsp_data=lfsr_pout (stable due to hold), rsp_id=captured id.
  - rsp_valid, rsp_data and rsp_id are held until rsp_ready.
  - On rsp_valid&&rsp_ready: go to IDLE, rr_ptr = ~rsp_id.
- Latency, counted from the accepting edge:
  - load=1: rsp_valid rises after 1+N+1 edges (cycle N+2).
  - load=0: rsp_valid rises in cycle N+1.
  - load=0, steps=0: rsp_valid rises in cycle 1 and returns the current value, even 0.
- Throughput: one request in flight. A new grant is possible in the cycle after the response handshake.
- rsp_ready while not in RESP is ignored. reqN_valid dropped without a handshake has no effect.
- Zero seed with load=1: DEFAULT_SEED is loaded. No error signalled.

Test Plan:
- After reset, req0 load=1 seed=6'h20 steps=1 → rsp_valid in cycle 3, rsp_data=6'h0B, rsp_id=0; LFSR holds 6'h0B afterwards.
- req1 load=1 seed=6'h20 steps=3 → lfsr_sel high exactly 3 cycles, rsp_data=6'h2E, rsp_id=1; then req0 load=0 steps=0 → rsp_data=6'h2E in cycle 1.
- req0 and req1 both valid continuously, each load=1 seed=6'h20 steps=2 → grants alternate 0,1,0,1 with rsp_data=6'h16 each; only one ready high per cycle.
- Immediately after reset (LFSR=0), req0 load=0 steps=2 → first SHIFT cycle reseeds 6'h20, second shifts → rsp_data=6'h0B.
- req0 load=1 seed=0 steps=1 → DEFAULT_SEED used, rsp_data=6'h0B. Then hold rsp_ready=0 for 5 cycles → rsp_data/rsp_id stable and lfsr_pout unchanged.
- Assert rst_n low during SHIFT of a steps=15 request → rsp_valid=0, busy=0, lfsr_sel=0 asynchronously. After release, req1 is granted first only if req0 is not valid (rr_ptr=0).
